// File: rtl/mission_sequencer.sv
// Mission sequencer: arms a robot over UART, plays a table of drive segments
// for a programmable number of laps, and always finishes with a stop frame.
module mission_sequencer #(
   parameter int CLK_HZ = 100_000_000,
   parameter int BAUD   = 57600,
   parameter int N_SEG  = 4,
   parameter int MS_W   = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [7:0]             sw,
   input  logic                   btnu,
   input  logic                   btns,
   input  logic                   btnd,
   input  logic [16*N_SEG-1:0]    seg_vel,
   input  logic [16*N_SEG-1:0]    seg_rad,
   input  logic [MS_W*N_SEG-1:0]  seg_ms,
   output logic                   TxD,
   output logic [7:0]             Led
);

   localparam int BIT   = CLK_HZ / BAUD;
   localparam int TICKS = CLK_HZ / 1000;
   localparam int BW    = $clog2(BIT + 1);
   localparam int TW    = $clog2(TICKS + 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(BIT - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICKS - 1);
   localparam logic [4:0]    SEG_LAST  = 5'(N_SEG - 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ARMING   = 3'd1,
      ST_ARMED    = 3'd2,
      ST_SEND     = 3'd3,
      ST_WAIT     = 3'd4,
      ST_STOPPING = 3'd5
   } state_t;

   // Segment table unpacked to 32 entries so a 5-bit index selects cleanly.
   logic [15:0]     vel_arr [32];
   logic [15:0]     rad_arr [32];
   logic [MS_W-1:0] ms_arr  [32];

   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_seg
         if (gi < N_SEG) begin : g_used
            assign vel_arr[gi] = seg_vel[16*gi +: 16];
            assign rad_arr[gi] = seg_rad[16*gi +: 16];
            assign ms_arr[gi]  = seg_ms[MS_W*gi +: MS_W];
         end else begin : g_pad
            assign vel_arr[gi] = 16'h0000;
            assign rad_arr[gi] = 16'h0000;
            assign ms_arr[gi]  = '0;
         end
      end
   endgenerate

   logic unused_sw;
   assign unused_sw = ^sw[6:4];

   // Button synchronisers: bit 0 = btnu, bit 1 = btns, bit 2 = btnd.
   logic [2:0] sync1_reg, sync2_reg, sync3_reg, pulse;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
         sync3_reg <= '0;
      end else begin
         sync1_reg <= {btnd, btns, btnu};
         sync2_reg <= sync1_reg;
         sync3_reg <= sync2_reg;
      end
   end
   assign pulse = sync2_reg & ~sync3_reg;

   state_t              state_reg, state_next;
   logic [4:0]          index_reg, index_next;
   logic [3:0]          lap_reg, lap_next;
   logic                entry_reg;
   logic [MS_W-1:0]     ms_reg, ms_cnt_reg;
   logic [TW-1:0]       tick_reg;
   logic [7:0]          led_reg;

   // UART engine state: frame_reg holds unsent bytes, MSB byte goes next.
   logic [39:0]         frame_reg, frame_in, src_frame;
   logic [2:0]          left_reg, len_in, src_left;
   logic                busy_reg, start_frame, stop_end, load, tx_done;
   logic [9:0]          sh_reg;
   logic [3:0]          bit_reg;
   logic [BW-1:0]       baud_reg;

   logic abort, expired;
   assign abort   = pulse[2] | ~sw[7];
   assign expired = (ms_cnt_reg == ms_reg);

   // Next-state logic and frame requests; a newly requested frame replaces
   // any bytes not yet started, but never the byte already on the wire.
   always_comb begin
      state_next  = state_reg;
      index_next  = index_reg;
      lap_next    = lap_reg;
      start_frame = 1'b0;
      frame_in    = '0;
      len_in      = 3'd0;
      case (state_reg)
         ST_IDLE: begin
            if (pulse[0]) state_next = ST_ARMING;
         end
         ST_ARMING: begin
            if (entry_reg) begin
               start_frame = 1'b1;
               frame_in    = {8'h80, 8'h84, 24'h000000};
               len_in      = 3'd2;
            end
            if (tx_done) state_next = ST_ARMED;
         end
         ST_ARMED: begin
            if (pulse[1] && sw[7]) begin
               state_next = ST_SEND;
               index_next = 5'd0;
               lap_next   = sw[3:0];
            end
         end
         ST_SEND: begin
            if (abort) begin
               state_next  = ST_STOPPING;
               start_frame = 1'b1;
               frame_in    = {8'h89, 32'h0};
               len_in      = 3'd5;
            end else begin
               if (entry_reg) begin
                  start_frame = 1'b1;
                  frame_in    = {8'h89, vel_arr[index_reg], rad_arr[index_reg]};
                  len_in      = 3'd5;
               end
               if (tx_done) state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (abort || (expired && index_reg == SEG_LAST && lap_reg == 4'd0)) begin
               state_next  = ST_STOPPING;
               start_frame = 1'b1;
               frame_in    = {8'h89, 32'h0};
               len_in      = 3'd5;
            end else if (expired) begin
               state_next = ST_SEND;
               if (index_reg != SEG_LAST) begin
                  index_next = index_reg + 5'd1;
               end else begin
                  index_next = 5'd0;
                  lap_next   = lap_reg - 4'd1;
               end
            end
         end
         ST_STOPPING: begin
            if (tx_done) begin
               state_next = ST_ARMED;
               index_next = 5'd0;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Sequencer registers; segment duration is latched on the first SEND cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         index_reg <= 5'd0;
         lap_reg   <= 4'd0;
         entry_reg <= 1'b0;
         ms_reg    <= '0;
         led_reg   <= 8'h00;
      end else begin
         state_reg <= state_next;
         index_reg <= index_next;
         lap_reg   <= lap_next;
         entry_reg <= (state_next != state_reg);
         if (state_reg == ST_SEND && entry_reg) ms_reg <= ms_arr[index_reg];
         led_reg   <= {state_reg, index_reg};
      end
   end

   // Millisecond timer; held at zero whenever not actively waiting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_reg   <= '0;
         ms_cnt_reg <= '0;
      end else if (state_reg == ST_WAIT && !abort && !expired) begin
         if (tick_reg == TICK_LAST) begin
            tick_reg   <= '0;
            ms_cnt_reg <= ms_cnt_reg + 1'b1;
         end else begin
            tick_reg <= tick_reg + 1'b1;
         end
      end else begin
         tick_reg   <= '0;
         ms_cnt_reg <= '0;
      end
   end

   assign src_frame = start_frame ? frame_in : frame_reg;
   assign src_left  = start_frame ? len_in : left_reg;
   assign stop_end  = busy_reg && baud_reg == BIT_LAST && bit_reg == 4'd9;
   assign load      = (src_left != 3'd0) && (!busy_reg || stop_end);
   assign tx_done   = stop_end && left_reg == 3'd0;

   // 8N1 transmitter; the next byte is loaded during the last stop-bit clock
   // so consecutive bytes run with no idle gap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_reg <= '0;
         left_reg  <= 3'd0;
         busy_reg  <= 1'b0;
         sh_reg    <= '1;
         bit_reg   <= 4'd0;
         baud_reg  <= '0;
      end else if (load) begin
         sh_reg    <= {1'b1, src_frame[39:32], 1'b0};
         frame_reg <= {src_frame[31:0], 8'h00};
         left_reg  <= src_left - 3'd1;
         busy_reg  <= 1'b1;
         bit_reg   <= 4'd0;
         baud_reg  <= '0;
      end else begin
         frame_reg <= src_frame;
         left_reg  <= src_left;
         if (busy_reg) begin
            if (baud_reg == BIT_LAST) begin
               baud_reg <= '0;
               if (bit_reg == 4'd9) begin
                  busy_reg <= 1'b0;
               end else begin
                  bit_reg <= bit_reg + 4'd1;
                  sh_reg  <= {1'b1, sh_reg[9:1]};
               end
            end else begin
               baud_reg <= baud_reg + 1'b1;
            end
         end
      end
   end

   assign TxD = busy_reg ? sh_reg[0] : 1'b1;
   assign Led = led_reg;

endmodule

// File: tb/tb_mission_sequencer.sv
// Bench for mission_sequencer: a UART receiver model feeds a byte scoreboard,
// plus a table of ignored-button vectors and hand-written corner sequences.
module tb_mission_sequencer;

   logic                clk;
   logic                rst_n;
   logic [7:0]          sw;
   logic                btnu, btns, btnd;
   logic [31:0]         seg_vel, seg_rad, seg_ms;
   logic                TxD;
   logic [7:0]          Led;

   mission_sequencer #(
      .CLK_HZ(1_000_000), .BAUD(100_000), .N_SEG(2), .MS_W(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sw(sw), .btnu(btnu), .btns(btns), .btnd(btnd),
      .seg_vel(seg_vel), .seg_rad(seg_rad), .seg_ms(seg_ms),
      .TxD(TxD), .Led(Led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          rx_cnt   = 0;
   bit          mon_busy = 0;
   logic [7:0]  exp_q[$];
   int          t_q[$];

   localparam logic [39:0] D0    = 40'h89_00C8_01F4;
   localparam logic [39:0] D1    = 40'h89_FF38_FE0C;
   localparam logic [39:0] STOPF = 40'h89_0000_0000;

   typedef struct {
      logic [7:0] sw;
      logic [2:0] btn;      // {btnd, btns, btnu}
      logic [7:0] exp_led;
      int         exp_bytes;
   } vec_t;
   vec_t vecs[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic chk_rng(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act >= lo && act <= hi) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
   endtask

   task automatic mon_wait(input int n, inout bit r);
      repeat (n) begin
         @(negedge clk);
         if (!rst_n) r = 1'b1;
      end
   endtask

   // UART receiver: samples mid-bit, abandons any byte cut by reset.
   always begin : uart_mon
      bit         rst_seen;
      logic [7:0] d;
      logic [7:0] e;
      @(negedge clk);
      if (rst_n === 1'b1 && TxD === 1'b0) begin
         mon_busy = 1'b1;
         rst_seen = 1'b0;
         t_q.push_back(cyc);
         mon_wait(4, rst_seen);
         for (int b = 0; b < 8; b++) begin
            mon_wait(10, rst_seen);
            d[b] = TxD;
         end
         mon_wait(10, rst_seen);
         if (!rst_seen) begin
            chk("stop_bit", {31'd0, TxD}, 32'd1);
            rx_cnt++;
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL rx_unexpected: got %02h, expected no byte", d);
            end else begin
               e = exp_q.pop_front();
               $display("rx byte %02h (expected %02h) at cycle %0d", d, e, cyc);
               chk("rx_byte", {24'd0, d}, {24'd0, e});
            end
         end
         mon_busy = 1'b0;
      end
   end

   task automatic push_frame(input logic [39:0] f);
      for (int i = 4; i >= 0; i--) exp_q.push_back(f[8*i +: 8]);
   endtask

   task automatic press(input logic [2:0] m);
      {btnd, btns, btnu} = m;
      repeat (4) @(negedge clk);
      {btnd, btns, btnu} = 3'b000;
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_rx(input int n, input string name);
      int k = 0;
      while (rx_cnt < n && k < 20000) begin
         @(negedge clk);
         k++;
      end
      chk(name, {31'd0, rx_cnt >= n}, 32'd1);
   endtask

   task automatic wait_starts(input int n, input string name);
      int k = 0;
      while (t_q.size() < n && k < 20000) begin
         @(negedge clk);
         k++;
      end
      chk(name, {31'd0, t_q.size() >= n}, 32'd1);
   endtask

   task automatic wait_done(input string name);
      int k = 0;
      while (!(exp_q.size() == 0 && !mon_busy && Led == 8'h40) && k < 20000) begin
         @(negedge clk);
         k++;
      end
      chk({name, "_led"}, {24'd0, Led}, 32'h40);
      chk({name, "_pending"}, exp_q.size(), 32'd0);
      repeat (150) @(negedge clk);
   endtask

   // Byte timing: back-to-back inside a frame, segment wait between frames.
   task automatic chk_frames(input int nframes, input string name);
      int ms;
      if (t_q.size() < nframes * 5) begin
         chk({name, "_nbytes"}, t_q.size(), nframes * 5);
         return;
      end
      for (int k = 1; k < nframes * 5; k++) begin
         if (k % 5 != 0) begin
            chk($sformatf("%s_b2b%0d", name, k), t_q[k] - t_q[k-1], 32'd100);
         end else begin
            ms = (((k / 5) - 1) % 2 == 0) ? 2 : 1;
            chk_rng($sformatf("%s_gap%0d", name, k), t_q[k] - (t_q[k-1] + 100),
                    ms * 1000, ms * 1000 + 4);
         end
      end
   endtask

   initial begin
      int cdrop;
      vecs[0] = '{sw: 8'h00, btn: 3'b010, exp_led: 8'h40, exp_bytes: 0};
      vecs[1] = '{sw: 8'h0F, btn: 3'b010, exp_led: 8'h40, exp_bytes: 0};
      vecs[2] = '{sw: 8'h80, btn: 3'b100, exp_led: 8'h40, exp_bytes: 0};
      vecs[3] = '{sw: 8'h80, btn: 3'b001, exp_led: 8'h40, exp_bytes: 0};

      seg_vel = {16'hFF38, 16'h00C8};
      seg_rad = {16'hFE0C, 16'h01F4};
      seg_ms  = {16'd1, 16'd2};
      sw = 8'h00;
      {btnd, btns, btnu} = 3'b000;
      rst_n = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_txd", {31'd0, TxD}, 32'd1);
      chk("reset_led", {24'd0, Led}, 32'h00);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_led", {24'd0, Led}, 32'h00);

      // Arm: 0x80 then 0x84 back-to-back
      t_q.delete();
      exp_q.push_back(8'h80);
      exp_q.push_back(8'h84);
      press(3'b001);
      wait_done("arm");
      if (t_q.size() >= 2) chk("arm_b2b", t_q[1] - t_q[0], 32'd100);
      else chk("arm_nbytes", t_q.size(), 32'd2);

      // Ignored buttons in ARMED
      for (int i = 0; i < 4; i++) begin
         sw = vecs[i].sw;
         t_q.delete();
         press(vecs[i].btn);
         repeat (200) @(negedge clk);
         chk($sformatf("vec%0d_led", i), {24'd0, Led}, {24'd0, vecs[i].exp_led});
         chk($sformatf("vec%0d_bytes", i), t_q.size(), vecs[i].exp_bytes);
      end

      // One lap
      sw = 8'h80;
      t_q.delete();
      rx_cnt = 0;
      push_frame(D0); push_frame(D1); push_frame(STOPF);
      press(3'b010);
      wait_rx(5, "lap1_f0");
      repeat (100) @(negedge clk);
      chk("lap1_wait0_led", {24'd0, Led}, 32'h80);
      wait_rx(10, "lap1_f1");
      repeat (100) @(negedge clk);
      chk("lap1_wait1_led", {24'd0, Led}, 32'h81);
      wait_done("lap1");
      chk_frames(3, "lap1");

      // Two laps, started with simultaneous btns+btnd (go wins)
      sw = 8'h81;
      t_q.delete();
      rx_cnt = 0;
      push_frame(D0); push_frame(D1); push_frame(D0); push_frame(D1); push_frame(STOPF);
      press(3'b110);
      wait_rx(15, "lap2_f2");
      repeat (100) @(negedge clk);
      chk("lap2_wait2_led", {24'd0, Led}, 32'h80);
      wait_done("lap2");
      chk_frames(5, "lap2");

      // Abort with btnd during the 3rd byte of the first drive frame
      sw = 8'h80;
      t_q.delete();
      rx_cnt = 0;
      exp_q.push_back(8'h89); exp_q.push_back(8'h00); exp_q.push_back(8'hC8);
      push_frame(STOPF);
      press(3'b010);
      wait_starts(3, "abort_b3");
      repeat (20) @(negedge clk);
      press(3'b100);
      wait_done("abort");
      if (t_q.size() >= 4) chk("abort_b2b", t_q[3] - t_q[2], 32'd100);
      else chk("abort_nbytes", t_q.size(), 32'd8);

      // Enable dropped during WAIT
      t_q.delete();
      rx_cnt = 0;
      push_frame(D0);
      press(3'b010);
      wait_rx(5, "swdrop_f0");
      repeat (500) @(negedge clk);
      chk("swdrop_wait_led", {24'd0, Led}, 32'h80);
      push_frame(STOPF);
      sw = 8'h00;
      cdrop = cyc;
      wait_rx(10, "swdrop_stop");
      if (t_q.size() >= 6) chk_rng("swdrop_latency", t_q[5] - cdrop, 1, 3);
      else chk("swdrop_nbytes", t_q.size(), 32'd10);
      wait_done("swdrop");

      // Reset mid-byte, then go ignored until re-armed
      sw = 8'h80;
      t_q.delete();
      press(3'b010);
      wait_starts(1, "rst_start");
      repeat (35) @(negedge clk);
      chk("pre_reset_txd", {31'd0, TxD}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("rst_txd", {31'd0, TxD}, 32'd1);
      chk("rst_led", {24'd0, Led}, 32'h00);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      exp_q.delete();
      t_q.delete();
      press(3'b010);
      repeat (300) @(negedge clk);
      chk("post_rst_led", {24'd0, Led}, 32'h00);
      chk("post_rst_bytes", t_q.size(), 32'd0);
      exp_q.push_back(8'h80);
      exp_q.push_back(8'h84);
      press(3'b001);
      wait_done("rearm");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
